// File: rtl/alu_uart_interface_pkg.sv
// rtl/alu_uart_interface_pkg.sv - FSM state encodings and ALU opcodes shared by the sequencer, the ALU and the bench.
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    S_DATA_1  = 3'd0,
    S_DATA_2  = 3'd1,
    S_OPCODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

endpackage

// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - collects operand/operand/opcode bytes from the UART receiver,
// holds them on the ALU inputs and hands the captured result to the UART transmitter.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_data_1,
  output logic [NB_DATA-1:0] o_alu_data_2,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_rx_dropped
);

  state_t               r_state;
  state_t               w_next_state;
  logic [NB_DATA-1:0]   r_data_1;
  logic [NB_DATA-1:0]   r_data_2;
  logic [NB_OP-1:0]     r_op;
  logic [NB_DATA-1:0]   r_tx_data;
  logic                 r_rx_dropped;
  logic                 w_busy;
  logic                 w_unused_rx_bits;

  // Opcode bytes carry spare upper bits that are deliberately discarded.
  assign w_unused_rx_bits = ^i_rx_data[NB_DATA-1:NB_OP];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_DATA_1:  if (i_rx_done) w_next_state = S_DATA_2;
      S_DATA_2:  if (i_rx_done) w_next_state = S_OPCODE;
      S_OPCODE:  if (i_rx_done) w_next_state = S_EXEC;
      S_EXEC:    w_next_state = S_SEND;
      S_SEND:    w_next_state = S_WAIT_TX;
      S_WAIT_TX: if (i_tx_done) w_next_state = S_DATA_1;
      default:   w_next_state = S_DATA_1;
    endcase
  end

  assign w_busy = (r_state == S_EXEC) || (r_state == S_SEND) || (r_state == S_WAIT_TX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_DATA_1;
      r_data_1     <= '0;
      r_data_2     <= '0;
      r_op         <= '0;
      r_tx_data    <= '0;
      r_rx_dropped <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_DATA_1: if (i_rx_done) r_data_1 <= i_rx_data;
        S_DATA_2: if (i_rx_done) r_data_2 <= i_rx_data;
        S_OPCODE: if (i_rx_done) r_op <= i_rx_data[NB_OP-1:0];
        S_EXEC:   r_tx_data <= i_alu_result;
        default:  ;
      endcase
      // Bytes arriving while a result is in flight are lost; flag it until reset.
      if (i_rx_done && w_busy) r_rx_dropped <= 1'b1;
    end
  end

  assign o_alu_data_1 = r_data_1;
  assign o_alu_data_2 = r_data_2;
  assign o_alu_op     = r_op;
  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = (r_state == S_SEND);
  assign o_busy       = w_busy;
  assign o_rx_dropped = r_rx_dropped;

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb/tb_alu_uart_interface.sv - directed and randomized bench with a behavioural ALU attached.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_data_1;
  logic [7:0] o_alu_data_2;
  logic [5:0] o_alu_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_rx_dropped;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_d1, exp_d2;
  logic [5:0] exp_op;
  logic       exp_dropped;

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_alu_result(i_alu_result), .o_alu_data_1(o_alu_data_1),
    .o_alu_data_2(o_alu_data_2), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_rx_dropped(o_rx_dropped)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRL:  return a >> b;
      OP_SRA:  return $unsigned($signed(a) >>> b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = alu_ref(o_alu_data_1, o_alu_data_2, o_alu_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_d1"}, o_alu_data_1, 0);
    check({tag, "_d2"}, o_alu_data_2, 0);
    check({tag, "_op"}, o_alu_op, 0);
    check({tag, "_txd"}, o_tx_data, 0);
    check({tag, "_start"}, o_tx_start, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_drop"}, o_rx_dropped, 0);
  endtask

  // Sends a triple and walks EXEC and SEND; leaves the DUT waiting for tx completion.
  task automatic do_triple(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] exp_res, input bit early_td);
    send_byte(a);
    exp_d1 = a;
    check({tag, "_d1"}, o_alu_data_1, exp_d1);
    check({tag, "_idle1"}, o_busy, 0);
    send_byte(b);
    exp_d2 = b;
    check({tag, "_d2"}, o_alu_data_2, exp_d2);
    i_tx_done = early_td;
    send_byte(c);
    exp_op = c[5:0];
    check({tag, "_op"}, o_alu_op, exp_op);
    check({tag, "_exec_busy"}, o_busy, 1);
    check({tag, "_exec_start"}, o_tx_start, 0);
    tick();
    i_tx_done = 1'b0;
    check({tag, "_start"}, o_tx_start, 1);
    check({tag, "_txd"}, o_tx_data, exp_res);
    check({tag, "_send_busy"}, o_busy, 1);
    tick();
    check({tag, "_start_once"}, o_tx_start, 0);
    check({tag, "_wait_busy"}, o_busy, 1);
  endtask

  task automatic finish_tx(input string tag, input int idle);
    for (int k = 0; k < idle; k++) begin
      tick();
      check({tag, "_hold_busy"}, o_busy, 1);
      check({tag, "_hold_start"}, o_tx_start, 0);
    end
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check({tag, "_done_busy"}, o_busy, 0);
    check({tag, "_drop"}, o_rx_dropped, exp_dropped);
  endtask

  initial begin
    logic [7:0] a, b, c;
    i_reset = 1'b1; i_rx_data = '0; i_rx_done = 1'b0; i_tx_done = 1'b0;
    exp_dropped = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    check_reset_state("reset");

    do_triple("add", 8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    finish_tx("add", 3);

    do_triple("sub_wrap", 8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    finish_tx("sub_wrap", 1);
    do_triple("nor", 8'hF0, 8'h0F, 8'h27, 8'h00, 1'b0);
    finish_tx("nor", 0);

    do_triple("trunc", 8'hAA, 8'h55, 8'hE5, 8'hFF, 1'b1);
    check("trunc_op", o_alu_op, 6'h25);
    finish_tx("trunc", 2);
    do_triple("invalid", 8'h01, 8'h01, 8'h3F, 8'h00, 1'b0);
    finish_tx("invalid", 1);

    do_triple("drop", 8'h12, 8'h34, 8'h20, 8'h46, 1'b0);
    check("drop_pre", o_rx_dropped, 0);
    send_byte(8'h77);
    exp_dropped = 1'b1;
    check("drop_d1", o_alu_data_1, 8'h12);
    check("drop_d2", o_alu_data_2, 8'h34);
    check("drop_flag", o_rx_dropped, 1);
    check("drop_busy", o_busy, 1);
    finish_tx("drop", 1);

    do_triple("simul", 8'h21, 8'h02, 8'h02, 8'h08, 1'b0);
    i_tx_done = 1'b1;
    send_byte(8'h11);
    i_tx_done = 1'b0;
    check("simul_busy", o_busy, 0);
    check("simul_d1", o_alu_data_1, 8'h21);
    check("simul_drop", o_rx_dropped, 1);
    do_triple("after_simul", 8'h80, 8'h01, 8'h03, 8'hC0, 1'b0);
    finish_tx("after_simul", 0);

    send_byte(8'h09);
    send_byte(8'h04);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    exp_dropped = 1'b0;
    check_reset_state("midreset");
    do_triple("post_reset", 8'h02, 8'h02, 8'h20, 8'h04, 1'b0);
    finish_tx("post_reset", 1);

    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 8))
        0: c = {2'($urandom), OP_ADD};
        1: c = {2'($urandom), OP_SUB};
        2: c = {2'($urandom), OP_AND};
        3: c = {2'($urandom), OP_OR};
        4: c = {2'($urandom), OP_XOR};
        5: c = {2'($urandom), OP_NOR};
        6: c = {2'($urandom), OP_SRL};
        7: c = {2'($urandom), OP_SRA};
        default: c = 8'($urandom);
      endcase
      if (c[5:0] == OP_SRL || c[5:0] == OP_SRA) b = 8'($urandom_range(0, 9));
      do_triple($sformatf("rnd%0d", n), a, b, c, alu_ref(a, b, c[5:0]), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom));
        exp_dropped = 1'b1;
        check($sformatf("rnd%0d_keep_d1", n), o_alu_data_1, a);
      end
      finish_tx($sformatf("rnd%0d", n), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
